// File: rtl/i2s_bclk_lrck_gen_if.sv
// Signal bundle between the bit/frame clock generator and its users:
// config in from the factor parser, clocks/strobes/positions out to the serdes.
interface i2s_bclk_lrck_gen_if;
    logic       en;
    logic [4:0] bclk_factor_real;
    logic [4:0] tdm_slots;
    logic       fmt;
    logic       bclk;
    logic       lrck;
    logic       bclk_fall;
    logic       bclk_rise;
    logic [3:0] slot_idx;
    logic [4:0] bit_idx;
    logic       frame_start;

    modport master (
        input  en, bclk_factor_real, tdm_slots, fmt,
        output bclk, lrck, bclk_fall, bclk_rise, slot_idx, bit_idx, frame_start
    );

    modport slave (
        output en, bclk_factor_real, tdm_slots, fmt,
        input  bclk, lrck, bclk_fall, bclk_rise, slot_idx, bit_idx, frame_start
    );
endinterface

// File: rtl/i2s_bclk_lrck_gen.sv
// I2S/TDM bit clock and frame clock generator with edge strobes and slot/bit
// position counters; config is shadowed and only swapped at frame boundaries.
module i2s_bclk_lrck_gen #(
    parameter int SLOT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    i2s_bclk_lrck_gen_if.master   bus
);
    localparam logic [4:0] BIT_LAST = 5'(SLOT_WIDTH - 1);

    typedef struct packed {
        logic [4:0] f;
        logic [4:0] n;
        logic       fmt;
    } cfg_t;

    cfg_t       cfg_in, cfg_q;
    logic       run_q;
    logic [4:0] div_cnt;
    logic       bclk_q, lrck_q, fall_q, rise_q, frame_q;
    logic [3:0] slot_q, slot_nx;
    logic [4:0] bit_q, bit_nx;
    logic [4:0] half, slot_p1;
    logic       tc, fall_ev, rise_ev, lrck_nx, frame_nx;

    always_comb begin
        cfg_in.f   = (bus.bclk_factor_real == 5'd0) ? 5'd1 : bus.bclk_factor_real;
        cfg_in.n   = (bus.tdm_slots < 5'd3)  ? 5'd2  :
                     (bus.tdm_slots > 5'd16) ? 5'd16 : bus.tdm_slots;
        cfg_in.fmt = bus.fmt;
    end

    // First enabled edge only arms the divider, so the first fall lands F edges later.
    assign tc      = run_q && (div_cnt == cfg_q.f - 5'd1);
    assign fall_ev = tc && bclk_q;
    assign rise_ev = tc && !bclk_q;

    always_comb begin
        bit_nx  = (bit_q == BIT_LAST) ? 5'd0 : bit_q + 5'd1;
        slot_nx = slot_q;
        if (bit_q == BIT_LAST)
            slot_nx = ({1'b0, slot_q} == cfg_q.n - 5'd1) ? 4'd0 : slot_q + 4'd1;
        frame_nx = (bit_nx == 5'd0) && (slot_nx == 4'd0);
        half     = cfg_q.n >> 1;
        slot_p1  = {1'b0, slot_nx} + 5'd1;
        // I2S word select leads the data by one bit: on the last bit, look at the next slot.
        if (cfg_q.fmt)
            lrck_nx = ({1'b0, slot_nx} == cfg_q.n - 5'd1) && (bit_nx == BIT_LAST);
        else if (bit_nx == BIT_LAST)
            lrck_nx = (slot_p1 >= half) && (slot_p1 < cfg_q.n);
        else
            lrck_nx = ({1'b0, slot_nx} >= half);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !bus.en) begin
            run_q   <= 1'b0;
            div_cnt <= '0;
            bclk_q  <= 1'b1;
            lrck_q  <= 1'b0;
            fall_q  <= 1'b0;
            rise_q  <= 1'b0;
            frame_q <= 1'b0;
            slot_q  <= 4'(cfg_in.n - 5'd1);
            bit_q   <= BIT_LAST;
            cfg_q   <= cfg_in;
        end else begin
            run_q   <= 1'b1;
            fall_q  <= fall_ev;
            rise_q  <= rise_ev;
            frame_q <= fall_ev && frame_nx;
            if (tc) begin
                div_cnt <= '0;
                bclk_q  <= ~bclk_q;
            end else if (run_q) begin
                div_cnt <= div_cnt + 5'd1;
            end
            if (fall_ev) begin
                bit_q  <= bit_nx;
                slot_q <= slot_nx;
                lrck_q <= lrck_nx;
                if (frame_nx)
                    cfg_q <= cfg_in;
            end
        end
    end

    assign bus.bclk        = bclk_q;
    assign bus.lrck        = lrck_q;
    assign bus.bclk_fall   = fall_q;
    assign bus.bclk_rise   = rise_q;
    assign bus.slot_idx    = slot_q;
    assign bus.bit_idx     = bit_q;
    assign bus.frame_start = frame_q;
endmodule

// File: tb/tb_i2s_bclk_lrck_gen.sv
// Bench for i2s_bclk_lrck_gen: frame-time reference model checked every cycle,
// directed scenarios with literal timing pins, then randomized config/enable traffic.
module tb_i2s_bclk_lrck_gen;
    localparam int SW = 32;
    localparam int M_IDLE = 0, M_PRE = 1, M_RUN = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i2s_bclk_lrck_gen_if bus();
    i2s_bclk_lrck_gen #(.SLOT_WIDTH(SW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_chk = 0, n_fail = 0, cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int dec_f(input logic [4:0] v);
        return (v == 5'd0) ? 1 : int'(v);
    endfunction
    function automatic int dec_n(input logic [4:0] v);
        return (v < 5'd3) ? 2 : ((v > 5'd16) ? 16 : int'(v));
    endfunction

    // Reference: outputs derived from the elapsed edge count inside the current frame.
    int mode = M_IDLE, t = 0, idle_f = 1, idle_n = 2, rf = 1, rn = 2, rfmt = 0;
    bit m_valid = 1'b0;
    int e_bclk, e_lrck, e_fall, e_rise, e_slot, e_bit, e_fs;

    always @(posedge clk) begin
        int h, r, p, fl;
        cyc++;
        m_valid = 1'b1;
        if (!rst_n || !bus.en) begin
            mode   = M_IDLE;
            idle_f = dec_f(bus.bclk_factor_real);
            idle_n = dec_n(bus.tdm_slots);
        end else begin
            if (mode == M_IDLE) begin
                mode = M_PRE;
                t    = 0;
            end else begin
                t++;
            end
            if ((mode == M_PRE && t == idle_f) || (mode == M_RUN && t == 2 * rf * rn * SW)) begin
                mode = M_RUN;
                t    = 0;
                rf   = dec_f(bus.bclk_factor_real);
                rn   = dec_n(bus.tdm_slots);
                rfmt = bus.fmt ? 1 : 0;
            end
        end
        if (mode == M_RUN) begin
            h = t / rf; r = t % rf; p = h / 2; fl = rn * SW;
            e_bclk = h % 2;
            e_fall = (r == 0 && h % 2 == 0) ? 1 : 0;
            e_rise = (r == 0 && h % 2 == 1) ? 1 : 0;
            e_slot = p / SW;
            e_bit  = p % SW;
            e_fs   = (e_fall == 1 && p == 0) ? 1 : 0;
            if (rfmt == 1) e_lrck = (p == fl - 1) ? 1 : 0;
            else           e_lrck = ((((p + 1) % fl) / SW) >= rn / 2) ? 1 : 0;
        end else begin
            e_bclk = 1; e_lrck = 0; e_fall = 0; e_rise = 0; e_fs = 0;
            e_slot = (mode == M_IDLE ? idle_n : idle_n) - 1;
            e_bit  = SW - 1;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("bclk",        32'(bus.bclk),        e_bclk);
            chk("lrck",        32'(bus.lrck),        e_lrck);
            chk("bclk_fall",   32'(bus.bclk_fall),   e_fall);
            chk("bclk_rise",   32'(bus.bclk_rise),   e_rise);
            chk("slot_idx",    32'(bus.slot_idx),    e_slot);
            chk("bit_idx",     32'(bus.bit_idx),     e_bit);
            chk("frame_start", 32'(bus.frame_start), e_fs);
            chk("strobe_excl", 32'(bus.bclk_fall & bus.bclk_rise), 0);
        end
    end

    task automatic wait_fs(input int lim, output int at);
        bit found = 1'b0;
        at = -1;
        for (int i = 0; i < lim && !found; i++) begin
            @(negedge clk);
            if (bus.frame_start) begin found = 1'b1; at = cyc; end
        end
        chk("frame_start_seen", 32'(found), 1);
    endtask

    task automatic wait_pos(input int s, input int b, input int lim);
        bit found = 1'b0;
        for (int i = 0; i < lim && !found; i++) begin
            @(negedge clk);
            if (bus.bclk_fall && int'(bus.slot_idx) == s && int'(bus.bit_idx) == b) found = 1'b1;
        end
        chk("position_seen", 32'(found), 1);
    endtask

    initial begin
        int at, prev, en_edge, n;
        int flist[6] = '{0, 1, 2, 4, 8, 16};
        bus.en = 1'b0; bus.bclk_factor_real = 5'd1; bus.tdm_slots = 5'd2; bus.fmt = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_bclk", 32'(bus.bclk), 1);
        chk("rst_slot", 32'(bus.slot_idx), 1);
        chk("rst_bit",  32'(bus.bit_idx), 31);
        chk("rst_lrck", 32'(bus.lrck), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // F=1, N=2, I2S
        bus.en = 1'b1; en_edge = cyc + 1;
        wait_fs(10, at);
        chk("s1_first_fs", at - en_edge, 1);
        prev = at;
        wait_pos(0, 31, 200); chk("s1_lrck_s0b31", 32'(bus.lrck), 1);
        wait_pos(1, 30, 200); chk("s1_lrck_s1b30", 32'(bus.lrck), 1);
        wait_pos(1, 31, 200); chk("s1_lrck_s1b31", 32'(bus.lrck), 0);
        wait_fs(300, at);
        chk("s1_fs_period", at - prev, 128);

        // F=4, N=8, DSP
        bus.en = 1'b0; bus.bclk_factor_real = 5'd4; bus.tdm_slots = 5'd8; bus.fmt = 1'b1;
        @(negedge clk);
        bus.en = 1'b1; en_edge = cyc + 1;
        wait_fs(20, at);
        chk("s2_first_fs", at - en_edge, 4);
        prev = at;
        wait_fs(2100, at);
        chk("s2_fs_period", at - prev, 2048);
        n = 0;
        for (int i = 0; i < 2100 && !bus.lrck; i++) @(negedge clk);
        while (bus.lrck && n < 50) begin @(negedge clk); n++; end
        chk("s2_lrck_width", n, 8);
        chk("s2_lrck_end_fs", 32'(bus.frame_start), 1);

        // F 2 -> 16 mid-frame
        bus.en = 1'b0; bus.bclk_factor_real = 5'd2; bus.tdm_slots = 5'd2; bus.fmt = 1'b0;
        @(negedge clk);
        bus.en = 1'b1;
        wait_fs(10, at); prev = at;
        wait_pos(0, 10, 100);
        bus.bclk_factor_real = 5'd16;
        wait_fs(400, at);
        chk("s3_old_frame", at - prev, 256);
        prev = at;
        wait_fs(2100, at);
        chk("s3_new_frame", at - prev, 2048);

        // disable at slot 1 bit 5, re-enable 3 cycles later
        bus.en = 1'b0; bus.bclk_factor_real = 5'd2;
        @(negedge clk);
        bus.en = 1'b1;
        wait_fs(10, at);
        wait_pos(1, 5, 300);
        bus.en = 1'b0;
        @(negedge clk);
        chk("s4_drop_bclk", 32'(bus.bclk), 1);
        chk("s4_drop_slot", 32'(bus.slot_idx), 1);
        chk("s4_drop_bit",  32'(bus.bit_idx), 31);
        chk("s4_drop_fall", 32'(bus.bclk_fall), 0);
        repeat (2) @(negedge clk);
        bus.en = 1'b1; en_edge = cyc + 1;
        wait_fs(10, at);
        chk("s4_restart", at - en_edge, 2);

        // clamped factor / slot counts
        bus.en = 1'b0; bus.bclk_factor_real = 5'd0; bus.tdm_slots = 5'd0;
        @(negedge clk);
        bus.en = 1'b1; en_edge = cyc + 1;
        wait_fs(10, at);
        chk("s5_f0_first_fs", at - en_edge, 1);
        prev = at;
        wait_fs(300, at);
        chk("s5_n0_period", at - prev, 128);
        bus.tdm_slots = 5'd20; bus.bclk_factor_real = 5'd1;
        prev = at;
        wait_fs(300, at);
        chk("s5_pre_period", at - prev, 128);
        prev = at;
        wait_pos(15, 31, 1100);
        wait_fs(300, at);
        chk("s5_n20_period", at - prev, 1024);

        // one-cycle reset mid-frame with en held high
        bus.tdm_slots = 5'd2;
        repeat (37) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("s6_rst_bclk", 32'(bus.bclk), 1);
        chk("s6_rst_slot", 32'(bus.slot_idx), 1);
        chk("s6_rst_bit",  32'(bus.bit_idx), 31);
        chk("s6_rst_rise", 32'(bus.bclk_rise), 0);
        rst_n = 1'b1; en_edge = cyc + 1;
        wait_fs(10, at);
        chk("s6_restart", at - en_edge, 1);
        prev = at;
        wait_fs(300, at);
        chk("s6_fs_period", at - prev, 128);

        // randomized traffic; the per-cycle model does the checking
        for (int it = 0; it < 40; it++) begin
            bus.bclk_factor_real = 5'(flist[$urandom_range(0, 5)]);
            bus.tdm_slots        = 5'($urandom_range(0, 20));
            bus.fmt              = 1'($urandom_range(0, 1));
            bus.en               = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 5) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            repeat ($urandom_range(10, 500)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
